alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; all requirements below assume 32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port op  input  4  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA; 9-15 illegal.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; shift amount is b[4:0], shifted value is a.
REQ-008 SHALL have port out_valid  output  1  result and flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have ports zero, neg, carry, ovf, err  output  1 each  registered flags.

Function
REQ-012 SHALL compute AND using the existing and32 block; other ops in this module.
REQ-013 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-014 In IDLE: in_ready=1, out_valid=0; request accepted on edge where in_valid=1 and in_ready=1.
REQ-015 Non-shift op accepted at edge N: result/flags registered at N, state -> HOLD, out_valid=1 from N (visible cycle after edge N), latency 1.
REQ-016 Shift op with b[4:0]=0: treated as non-shift, result=a, latency 1.
REQ-017 Shift op with b[4:0]=k>0: a and counter k captured, state -> SHIFT; one bit shifted per cycle; counter reaches 0 after k edges -> HOLD; out_valid asserted k+1 cycles after acceptance.
REQ-018 In SHIFT: in_ready=0, out_valid=0; a, b, op changes ignored.
REQ-019 In HOLD: out_valid=1; result and flags SHALL stay stable until out_ready=1.
REQ-020 HOLD with out_ready=1 and in_valid=0: -> IDLE.
REQ-021 HOLD: in_ready=out_ready; with out_ready=1 and in_valid=1 the new request is accepted on the same edge (back-to-back, no bubble for 1-cycle ops).
REQ-022 SLL fills zeros at LSB; SRL fills zeros at MSB; SRA replicates a[31].
REQ-023 ADD: result=a+b mod 2^32; carry=bit-32 carry out; ovf=signed overflow.
REQ-024 SUB: result=a+~b+1; carry=carry out of that sum (1 = no borrow); ovf=signed overflow.
REQ-025 SLT: result=32'h1 if signed a<b else 0; correct for overflow cases.
REQ-026 carry and ovf SHALL be 0 for all ops other than ADD/SUB.
REQ-027 zero=(result==0); neg=result[31] for every op including shifts.
REQ-028 Illegal op: result=0, zero=1, neg=0, carry=0, ovf=0, err=1, latency 1; err=0 for legal ops.

Reset
REQ-029 rst_n=0 SHALL immediately, regardless of clk: state=IDLE, result=0, zero/neg/carry/ovf/err=0, out_valid=0, shift counter=0.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-031 Reset during SHIFT or HOLD SHALL discard the in-flight operation; no result is produced after release.

Verification
REQ-032 AND a=AAAAAAAA b=DDDDDDDD, out_ready=1 -> result=88888888, zero=0, neg=1, out_valid one cycle after accept.
REQ-033 ADD a=7FFFFFFF b=00000001 -> result=80000000, ovf=1, carry=0, neg=1; ADD a=FFFFFFFF b=00000001 -> result=0, carry=1, zero=1, ovf=0.
REQ-034 SUB a=00000005 b=00000005 -> result=0, zero=1, carry=1; SLT a=80000000 b=00000001 -> result=1.
REQ-035 SRA a=80000000 b=0000001F -> in_ready=0 for 31 cycles, out_valid 32 cycles after accept, result=FFFFFFFF; SLL same b=0 -> result=80000000, latency 1.
REQ-036 Hold out_ready=0 for 5 cycles after ADD result -> result/flags unchanged, in_ready=0; then out_ready=1 with in_valid=1 XOR a=F0F0F0F0 b=FFFFFFFF -> new result 0F0F0F0F next cycle, no bubble.
REQ-037 Pull rst_n low mid-SHIFT (SLL b=10) -> out_valid=0, result=0 immediately; op=0xC after release -> err=1, result=0, zero=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execute unit with valid/ready handshake.
// Shifts run one bit per cycle; all other ops complete in one cycle.
module and32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [1:0]       sop_q, sop_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] and_y;
  logic [WIDTH:0]   add_s, sub_s;
  logic             add_v, sub_v, slt;
  logic [WIDTH-1:0] alu_res, step;
  logic             alu_c, alu_v, alu_e;
  logic [SW-1:0]    shamt;
  logic             is_shift, accept;

  and32 #(.WIDTH(WIDTH)) u_and (
    .a (a),
    .b (b),
    .y (and_y)
  );

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign add_v = (a[WIDTH-1] == b[WIDTH-1])
               && (add_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] != b[WIDTH-1])
               && (sub_s[WIDTH-1] != a[WIDTH-1]);
  // sign of a-b corrected by overflow gives a true signed compare
  assign slt = sub_s[WIDTH-1] ^ sub_v;

  assign shamt    = b[SW-1:0];
  assign is_shift = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (op)
      4'd0: alu_res = and_y;
      4'd1: alu_res = a | b;
      4'd2: alu_res = a ^ b;
      4'd3: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c   = add_s[WIDTH];
        alu_v   = add_v;
      end
      4'd4: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c   = sub_s[WIDTH];
        alu_v   = sub_v;
      end
      4'd5: alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'd6, 4'd7, 4'd8: alu_res = a;
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    step = res_q;
    case (sop_q)
      2'd0:    step = {res_q[WIDTH-2:0], 1'b0};
      2'd1:    step = {1'b0, res_q[WIDTH-1:1]};
      2'd2:    step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
      default: step = res_q;
    endcase
  end

  assign in_ready = rst_n && ((state_q == IDLE)
                  || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept && is_shift && (shamt != '0)) begin
          state_d = SHIFT;
          res_d   = a;
          cnt_d   = shamt;
          sop_d   = 2'(op - 4'd6);
          zero_d  = 1'b0;
          neg_d   = 1'b0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end else if (accept) begin
          state_d = HOLD;
          res_d   = alu_res;
          zero_d  = (alu_res == '0);
          neg_d   = alu_res[WIDTH-1];
          carry_d = alu_c;
          ovf_d   = alu_v;
          err_d   = alu_e;
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = step;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = HOLD;
          zero_d  = (step == '0);
          neg_d   = step[WIDTH-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, neg, carry, ovf, err;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .err       (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // present a request for one edge, then drop in_valid
  task automatic do_op(input logic [3:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic rdy);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic shift_wait(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      if (in_ready) cnt = cnt + 100;
      cnt++;
      a  = $urandom;
      b  = $urandom;
      op = 4'(cnt);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {27'd0, zero, neg, carry, ovf, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    do_op(4'd0, 32'hAAAAAAAA, 32'hDDDDDDDD, 1'b1);
    check("and_valid", 32'(out_valid), 32'd1);
    check("and_res", result, 32'h88888888);
    check("and_zn", {30'd0, zero, neg}, 32'd1);

    do_op(4'd3, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    check("add_ovf_res", result, 32'h80000000);
    check("add_ovf_fl", {27'd0, zero, neg, carry, ovf, err}, 32'b01010);

    do_op(4'd3, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    check("add_c_res", result, 32'h0);
    check("add_c_fl", {27'd0, zero, neg, carry, ovf, err}, 32'b10100);

    do_op(4'd4, 32'h5, 32'h5, 1'b1);
    check("sub_res", result, 32'h0);
    check("sub_fl", {27'd0, zero, neg, carry, ovf, err}, 32'b10100);

    do_op(4'd4, 32'h3, 32'h5, 1'b1);
    check("sub_brw", result, 32'hFFFFFFFE);
    check("sub_brw_fl", {27'd0, zero, neg, carry, ovf, err}, 32'b01000);

    do_op(4'd5, 32'h80000000, 32'h1, 1'b1);
    check("slt_t", result, 32'h1);
    check("slt_t_cv", {30'd0, carry, ovf}, 32'd0);
    do_op(4'd5, 32'h1, 32'h80000000, 1'b1);
    check("slt_f", result, 32'h0);

    do_op(4'd1, 32'hF0F00000, 32'h0000000F, 1'b1);
    check("or_res", result, 32'hF0F0000F);

    do_op(4'd6, 32'h80000000, 32'h0, 1'b1);
    check("sll0_valid", 32'(out_valid), 32'd1);
    check("sll0_res", result, 32'h80000000);

    do_op(4'd8, 32'h80000000, 32'h1F, 1'b1);
    shift_wait(n);
    check("sra_cycles", 32'(n), 32'd31);
    check("sra_res", result, 32'hFFFFFFFF);
    check("sra_fl", {27'd0, zero, neg, carry, ovf, err}, 32'b01000);
    @(negedge clk);

    do_op(4'd7, 32'h80000000, 32'h4, 1'b1);
    shift_wait(n);
    check("srl_cycles", 32'(n), 32'd4);
    check("srl_res", result, 32'h08000000);
    @(negedge clk);

    do_op(4'd6, 32'h00000003, 32'h1F, 1'b1);
    shift_wait(n);
    check("sll_res", result, 32'h80000000);
    check("sll_zn", {30'd0, zero, neg}, 32'd1);
    @(negedge clk);

    do_op(4'd3, 32'h1, 32'h2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_res", result, 32'h3);
      check("hold_rdy", {30'd0, in_ready, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("hold_rel_rdy", 32'(in_ready), 32'd1);
    do_op(4'd2, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b1);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_res", result, 32'h0F0F0F0F);

    do_op(4'd6, 32'h1, 32'd10, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_res", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no_ghost", 32'(n), 32'd0);

    do_op(4'hC, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    check("ill_res", result, 32'h0);
    check("ill_fl", {27'd0, zero, neg, carry, ovf, err}, 32'b10001);
    do_op(4'd2, 32'h1, 32'h1, 1'b1);
    check("legal_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
